mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64: number of 32-bit words in the array (power of two).
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted before each response (0..15).
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_i  input  1  reset, synchronous and active-high.
REQ-005 req_i  input  1  access request from the multicycle controller; held until ready_o.
REQ-006 we_i  input  1  1 = write, 0 = read; valid with req_i.
REQ-007 addr_i32  input  32  byte address; valid with req_i.
REQ-008 wdata_i32  input  32  write data; valid with req_i.
REQ-009 rdata_o32  output  32  response data (instruction or load data).
REQ-010 ready_o  output  1  one-cycle pulse marking response completion.
REQ-011 busy_o  output  1  high while a request is in flight (WAIT or RESP).
REQ-012 misalign_o  output  1  sticky flag; an access used addr_i32[1:0] != 0.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-014 In IDLE with req_i=1, the block SHALL capture we_i, addr_i32 and wdata_i32 into internal registers.
- On that edge, it loads wait counter = WAIT_CYCLES.
- It moves to WAIT, or to RESP when WAIT_CYCLES=0.
REQ-015 In WAIT, the counter SHALL decrement each cycle; on the cycle it reads 1 the next state SHALL be RESP.
REQ-016 ready_o SHALL be 1 exactly in RESP.
- RESP is the (WAIT_CYCLES+1)th cycle after the accepting cycle.
- Latency is therefore WAIT_CYCLES+1 cycles.
REQ-017 RESP SHALL always return to IDLE; a req_i still high in RESP is not accepted, so the minimum request spacing is WAIT_CYCLES+2 cycles.
REQ-018 req_i, we_i, addr_i32 and wdata_i32 changes during WAIT or RESP SHALL be ignored; the captured values are used.
REQ-019 Word index SHALL be captured addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-020 Read: rdata_o32 SHALL load the indexed word on the RESP edge and be valid in the cycle ready_o=1.
REQ-021 Write: the array SHALL be updated on the RESP cycle edge, and rdata_o32 SHALL load the written data.
REQ-022 rdata_o32 SHALL hold its value between responses.
REQ-023 busy_o SHALL be 1 in WAIT and RESP, and 0 in IDLE.
REQ-024 Misaligned access (captured addr[1:0] != 0): the block SHALL set misalign_o.
- A write is suppressed (array unchanged).
- A read returns the aligned word.
- The response timing is unchanged.
REQ-025 misalign_o SHALL stay set until reset.
REQ-026 Read after write to the same word SHALL return the new value.

Reset
REQ-027 reset_i=1 on a clock edge SHALL force: state IDLE, counter 0, rdata_o32=0, ready_o=0, busy_o=0, misalign_o=0.
REQ-028 Reset during WAIT or RESP SHALL abort the access; a pending write is not committed.
REQ-029 Array contents SHALL NOT be cleared by reset.
REQ-030 Reset SHALL take priority over req_i in the same cycle.

Structure
REQ-031 The state enum (IDLE/WAIT/RESP) and word-width constant SHALL live in shared package mcp_mem_pkg.
REQ-032 Storage SHALL be a sub-module mem_word_array with one synchronous write port and one combinational read port; the FSM, counter and flags stay in mem_responder.

Verification (DEPTH_WORDS=64, WAIT_CYCLES=2 unless stated)
REQ-033 Write 0xDEADBEEF to 0x10, then read 0x10:
- ready_o pulses 3 cycles after each accept.
- The read returns 0xDEADBEEF.
- busy_o is high for 3 cycles per access.
REQ-034 Wrap: write 0x12345678 to 0x104, then read 0x004 -> 0x12345678.
REQ-035 Misaligned: write 0xFFFFFFFF to 0x22, then read 0x20:
- misalign_o rises and stays 1.
- The read returns the prior contents of word 8.
REQ-036 Reset mid-op: assert reset_i in the second WAIT cycle of a write of 0xAAAA5555 to 0x30:
- No ready_o pulse.
- A subsequent read of 0x30 returns the old value.
- All outputs are 0 the cycle after reset.
REQ-037 Request held high continuously across two reads: accepts are spaced exactly 4 cycles apart; address changes in WAIT have no effect.
REQ-038 WAIT_CYCLES=0 build: ready_o asserts 1 cycle after accept; read of reset-untouched preloaded word returns its preload value.

Source files
------------

// File: rtl/mcp_mem_pkg.sv
// Shared types and constants for the multicycle memory responder.
// Holds the responder state encoding and the data word width.
package mcp_mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word storage: one synchronous write port, one combinational read port.
// Contents are not reset; they survive responder resets.
module mem_word_array
  import mcp_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Multicycle memory responder: accepts one access, waits WAIT_CYCLES,
// then pulses ready_o with the read (or written) data for one cycle.
module mem_responder
  import mcp_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i32,
  input  logic [WORD_W-1:0] wdata_i32,
  output logic [WORD_W-1:0] rdata_o32,
  output logic              ready_o,
  output logic              busy_o,
  output logic              misalign_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_e state;
  state_e state_nx;
  logic [3:0] cnt;

  logic              cap_we;
  logic [AW-1:0]     cap_idx;
  logic              cap_mis;
  logic [WORD_W-1:0] cap_wdata;

  logic              accept;
  logic              live_mis;
  logic              cur_we;
  logic [AW-1:0]     cur_idx;
  logic [WORD_W-1:0] cur_wdata;
  logic [WORD_W-1:0] rd_word;
  logic              mem_we;
  logic              unused_addr;

  assign unused_addr = ^addr_i32[31:AW+2];

  assign accept   = (state == IDLE) && req_i;
  assign live_mis = is_misaligned(addr_i32[1:0]);

  // With zero wait states the response loads on the accept edge,
  // so the live request fields feed the datapath while idle.
  always_comb begin
    cur_we    = cap_we;
    cur_idx   = cap_idx;
    cur_wdata = cap_wdata;
    if (state == IDLE) begin
      cur_we    = we_i;
      cur_idx   = addr_i32[AW+1:2];
      cur_wdata = wdata_i32;
    end
  end

  // Commit on the edge leaving RESP so a reset in RESP drops the write.
  assign mem_we = (state == RESP) && cap_we && !cap_mis && !reset_i;

  mem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk_i),
    .we   (mem_we),
    .waddr(cap_idx),
    .wdata(cap_wdata),
    .raddr(cur_idx),
    .rdata(rd_word)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (req_i) begin
          state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      cnt        <= '0;
      rdata_o32  <= '0;
      misalign_o <= 1'b0;
      cap_we     <= 1'b0;
      cap_idx    <= '0;
      cap_mis    <= 1'b0;
      cap_wdata  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt       <= WAIT_LD;
        cap_we    <= we_i;
        cap_idx   <= addr_i32[AW+1:2];
        cap_mis   <= live_mis;
        cap_wdata <= wdata_i32;
        if (live_mis) begin
          misalign_o <= 1'b1;
        end
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end else begin
        cnt <= '0;
      end
      if (state_nx == RESP) begin
        rdata_o32 <= cur_we ? cur_wdata : rd_word;
      end
    end
  end

  assign ready_o = (state == RESP);
  assign busy_o  = (state != IDLE);

endmodule
